// File: rtl/wb_drain_ctrl_pkg.sv
// Shared definitions for the write-buffer drain controller: buffer geometry,
// line-address bit positions, FSM state encodings and the memory write record.
package wb_drain_ctrl_pkg;

  localparam int WB_LINES = 4;   // fixed: 2-bit line index
  localparam int WB_TAG_W = 27;  // address bits [31:5]

  // Line-address layout: [31:5] tag, [4:3] line, [2] word, [1:0] byte
  localparam int ADDR_TAG_LSB  = 5;
  localparam int ADDR_LINE_LSB = 3;
  localparam int ADDR_WORD_BIT = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_WR0  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_CLR  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_RD0  = S_RD0,
    ST_WR0  = S_WR0,
    ST_RD1  = S_RD1,
    ST_WR1  = S_WR1,
    ST_CLR  = S_CLR,
    ST_DONE = S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_wr_t;

  function automatic logic [31:0] mk_addr(input logic [WB_TAG_W-1:0] tag,
                                          input logic [1:0]          line,
                                          input logic                word);
    logic [31:0] a;
    a = '0;
    a[31:ADDR_TAG_LSB]        = tag;
    a[ADDR_LINE_LSB +: 2]     = line;
    a[ADDR_WORD_BIT]          = word;
    return a;
  endfunction

endpackage

// File: rtl/wb_drain_ctrl_if.sv
// Bundle between the drain controller, the write buffer and the SRAM write port.
//   master : the drain controller (drives strobes, line/word select, mem write)
//   slave  : the environment (write buffer + memory + trigger sources)
interface wb_drain_ctrl_if;

  logic                                  wb_full;
  logic                                  drain_req;
  logic                                  busy;
  logic                                  done;
  logic [1:0]                            wb_line;
  logic                                  wb_word;
  logic                                  wb_rd;
  logic                                  wb_clr;
  logic [wb_drain_ctrl_pkg::WB_TAG_W-1:0] wb_tag;
  logic                                  wb_tagval;
  logic [31:0]                           wb_rdata;
  logic [3:0]                            wb_rbe;
  logic                                  mem_req;
  logic [31:0]                           mem_addr;
  logic [31:0]                           mem_wdata;
  logic [3:0]                            mem_be;
  logic                                  mem_ack;

  modport master (
    input  wb_full, drain_req, wb_tag, wb_tagval, wb_rdata, wb_rbe, mem_ack,
    output busy, done, wb_line, wb_word, wb_rd, wb_clr,
           mem_req, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output wb_full, drain_req, wb_tag, wb_tagval, wb_rdata, wb_rbe, mem_ack,
    input  busy, done, wb_line, wb_word, wb_rd, wb_clr,
           mem_req, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/wb_drain_ctrl.sv
// Write-buffer drain controller. On wb_full or drain_req (sampled in IDLE) it
// walks all buffer lines, reads word 0 and word 1 of each valid line, issues
// one masked 32-bit write per non-empty word and then clears the line.
// Ports:
//   clk  - clock, posedge
//   rst  - asynchronous active-low reset
//   bus  - wb_drain_ctrl_if.master: triggers, write-buffer read/clear port,
//          memory write request/ack, busy/done status
// All outputs come from registers or a state decode; mem_ack only steers
// the next state.
module wb_drain_ctrl
  import wb_drain_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  wb_drain_ctrl_if.master bus
);

  state_t     r_state, w_next;
  logic [1:0] r_idx;
  mem_wr_t    r_wr;

  logic w_trig, w_last, w_rd, w_word;

  assign w_trig = bus.wb_full | bus.drain_req;
  assign w_last = (r_idx == 2'(WB_LINES - 1));
  assign w_rd   = (r_state == ST_RD0) | (r_state == ST_RD1);
  assign w_word = (r_state == ST_RD1) | (r_state == ST_WR1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_wr    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_trig)
        r_idx <= '0;
      else if (r_state == ST_CLR && !w_last)
        r_idx <= r_idx + 2'd1;
      // Capture on every read cycle; the WR state that follows holds it stable.
      if (w_rd) begin
        r_wr.addr  <= mk_addr(bus.wb_tag, r_idx, w_word);
        r_wr.wdata <= bus.wb_rdata;
        r_wr.be    <= bus.wb_rbe;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_trig) w_next = ST_RD0;
      ST_RD0: begin
        if (!bus.wb_tagval)       w_next = ST_CLR;
        else if (bus.wb_rbe == '0) w_next = ST_RD1;
        else                       w_next = ST_WR0;
      end
      ST_WR0: if (bus.mem_ack) w_next = ST_RD1;
      // Tag validity was already decided in RD0.
      ST_RD1: w_next = (bus.wb_rbe == '0) ? ST_CLR : ST_WR1;
      ST_WR1: if (bus.mem_ack) w_next = ST_CLR;
      ST_CLR:  w_next = w_last ? ST_DONE : ST_RD0;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (r_state != ST_IDLE);
    bus.done      = (r_state == ST_DONE);
    bus.wb_line   = r_idx;
    bus.wb_word   = w_word;
    bus.wb_rd     = w_rd;
    bus.wb_clr    = (r_state == ST_CLR);
    bus.mem_req   = (r_state == ST_WR0) | (r_state == ST_WR1);
    bus.mem_addr  = r_wr.addr;
    bus.mem_wdata = r_wr.wdata;
    bus.mem_be    = r_wr.be;
  end

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Scoreboard bench for wb_drain_ctrl: stimulus pushes expected writes, RD0
// lines, CLR lines and done latencies; a monitor pops and compares them.
module tb_wb_drain_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_drain_ctrl_if bus();
  wb_drain_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t q_wr[$];
  int  q_clr[$];
  int  q_rd[$];
  int  q_lat[$];

  int n_chk  = 0;
  int n_fail = 0;

  // staging (stimulus) and live (responder) copies of the buffer contents
  logic [26:0] s_tag[4];
  logic        s_tv[4];
  logic [3:0]  s_be[4][2];
  logic [31:0] s_dat[4][2];
  int          stall_cfg = 0;
  bit          hang_cfg  = 1'b0;
  int          load_seq  = 0;

  logic [26:0] m_tag[4];
  logic        m_tv[4];
  logic [3:0]  m_be[4][2];
  logic [31:0] m_dat[4][2];
  int          stall_rem;
  bit          hang;

  logic [31:0] full_addr[8];
  initial begin
    full_addr[0] = 32'h0000_2000; full_addr[1] = 32'h0000_2004;
    full_addr[2] = 32'h0000_2028; full_addr[3] = 32'h0000_202C;
    full_addr[4] = 32'h0000_2050; full_addr[5] = 32'h0000_2054;
    full_addr[6] = 32'h0000_2078; full_addr[7] = 32'h0000_207C;
  end

  always_comb begin
    bus.wb_tag    = m_tag[bus.wb_line];
    bus.wb_tagval = m_tv[bus.wb_line];
    bus.wb_rdata  = m_dat[bus.wb_line][bus.wb_word];
    bus.wb_rbe    = m_be[bus.wb_line][bus.wb_word];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // responder (ack, buffer clear) + scoreboard monitor
  initial begin
    int seen = 0;
    int bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = '0; m_tv[i] = 1'b0;
      m_be[i][0] = '0; m_be[i][1] = '0; m_dat[i][0] = '0; m_dat[i][1] = '0;
    end
    stall_rem   = 0;
    hang        = 1'b0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (load_seq != seen) begin
        seen = load_seq;
        for (int i = 0; i < 4; i++) begin
          m_tag[i] = s_tag[i]; m_tv[i] = s_tv[i];
          m_be[i][0] = s_be[i][0]; m_be[i][1] = s_be[i][1];
          m_dat[i][0] = s_dat[i][0]; m_dat[i][1] = s_dat[i][1];
        end
        stall_rem = stall_cfg;
        hang      = hang_cfg;
      end
      if (rst && bus.mem_req) begin
        if (hang && bus.wb_word)  bus.mem_ack = 1'b0;
        else if (stall_rem > 0) begin bus.mem_ack = 1'b0; stall_rem--; end
        else                      bus.mem_ack = 1'b1;
      end else
        bus.mem_ack = 1'b0;
      if (rst && bus.wb_clr) begin
        m_tv[bus.wb_line] = 1'b0;
        m_be[bus.wb_line][0] = '0;
        m_be[bus.wb_line][1] = '0;
      end
      #1;
      if (!rst) bcnt = 0;
      else begin
        if (bus.mem_req) begin
          if (q_wr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_write: got addr %h expected no request", bus.mem_addr);
          end else begin
            chk("wr_addr", bus.mem_addr,  q_wr[0].addr);
            chk("wr_data", bus.mem_wdata, q_wr[0].data);
            chk("wr_be",   32'(bus.mem_be), 32'(q_wr[0].be));
            if (bus.mem_ack) void'(q_wr.pop_front());
          end
        end
        if (bus.wb_clr) begin
          if (q_clr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_clr: got line %0d expected none", bus.wb_line);
          end else chk("clr_line", 32'(bus.wb_line), 32'(q_clr.pop_front()));
        end
        if (bus.wb_rd && !bus.wb_word) begin
          if (q_rd.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rd0: got line %0d expected none", bus.wb_line);
          end else chk("rd0_line", 32'(bus.wb_line), 32'(q_rd.pop_front()));
        end
        if (bus.busy) bcnt++; else bcnt = 0;
        if (bus.done) begin
          if (q_lat.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", bcnt);
          end else chk("done_latency", 32'(bcnt), 32'(q_lat.pop_front()));
        end
      end
    end
  end

  task automatic clear_stage();
    for (int i = 0; i < 4; i++) begin
      s_tag[i] = 27'h0; s_tv[i] = 1'b0;
      s_be[i][0] = 4'h0; s_be[i][1] = 4'h0;
      s_dat[i][0] = 32'h0; s_dat[i][1] = 32'h0;
    end
  endtask

  task automatic stage_full();
    for (int i = 0; i < 4; i++) begin
      s_tag[i] = 27'h000_0100 + 27'(i);
      s_tv[i]  = 1'b1;
      for (int w = 0; w < 2; w++) begin
        s_be[i][w]  = 4'hF;
        s_dat[i][w] = 32'hA500_0000 + 32'(i * 16 + w);
      end
    end
  endtask

  task automatic push_full();
    wr_t e;
    for (int k = 0; k < 8; k++) begin
      e.addr = full_addr[k];
      e.data = 32'hA500_0000 + 32'((k / 2) * 16 + (k % 2));
      e.be   = 4'hF;
      q_wr.push_back(e);
    end
  endtask

  task automatic push_walk(input int lat);
    for (int i = 0; i < 4; i++) begin
      q_rd.push_back(i);
      q_clr.push_back(i);
    end
    q_lat.push_back(lat);
  endtask

  task automatic commit();
    load_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse(input bit use_req);
    if (use_req) bus.drain_req = 1'b1; else bus.wb_full = 1'b1;
    @(negedge clk);
    bus.drain_req = 1'b0;
    bus.wb_full   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  task automatic drain_check();
    repeat (4) @(negedge clk);
    chk("wr_queue_left",  32'(q_wr.size()),  32'h0);
    chk("clr_queue_left", 32'(q_clr.size()), 32'h0);
    chk("rd_queue_left",  32'(q_rd.size()),  32'h0);
    chk("lat_queue_left", 32'(q_lat.size()), 32'h0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_busy"},    32'(bus.busy),    32'h0);
    chk({p, "_done"},    32'(bus.done),    32'h0);
    chk({p, "_wb_line"}, 32'(bus.wb_line), 32'h0);
    chk({p, "_wb_word"}, 32'(bus.wb_word), 32'h0);
    chk({p, "_wb_rd"},   32'(bus.wb_rd),   32'h0);
    chk({p, "_wb_clr"},  32'(bus.wb_clr),  32'h0);
    chk({p, "_mem_req"}, 32'(bus.mem_req), 32'h0);
    chk({p, "_mem_addr"}, bus.mem_addr,    32'h0);
    chk({p, "_mem_wdata"}, bus.mem_wdata,  32'h0);
    chk({p, "_mem_be"},  32'(bus.mem_be),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    int  n;
    rst = 1'b1;
    bus.wb_full   = 1'b0;
    bus.drain_req = 1'b0;
    clear_stage();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    commit();

    // full buffer, zero-wait ack
    stage_full(); stall_cfg = 0; hang_cfg = 1'b0; commit();
    push_full(); push_walk(21);
    pulse(1'b0);
    wait_done("full");
    drain_check();

    // partial masks: only line 2, word 0 = 4'b0011
    clear_stage();
    s_tag[2] = 27'h012_3456; s_tv[2] = 1'b1;
    s_be[2][0] = 4'b0011; s_dat[2][0] = 32'hCAFE_F00D;
    s_be[2][1] = 4'b0000; s_dat[2][1] = 32'hDEAD_BEEF;
    commit();
    e.addr = 32'h0246_8AD0; e.data = 32'hCAFE_F00D; e.be = 4'b0011;
    q_wr.push_back(e); push_walk(11);
    pulse(1'b1);
    wait_done("partial");
    drain_check();

    // ack stall of 3 cycles on the first write
    stage_full(); stall_cfg = 3; commit();
    push_full(); push_walk(24);
    pulse(1'b0);
    wait_done("stall");
    drain_check();
    stall_cfg = 0;

    // empty buffer, drain_req pulsed
    clear_stage(); commit();
    push_walk(9);
    pulse(1'b1);
    wait_done("empty");
    drain_check();

    // trigger held through DONE: restart from line 0 on a now-empty buffer
    stage_full(); commit();
    push_full(); push_walk(21); push_walk(9);
    bus.wb_full = 1'b1;
    wait_done("held_first");
    @(negedge clk);
    chk("held_idle_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("held_restart_busy", 32'(bus.busy), 32'h1);
    chk("held_restart_line", 32'(bus.wb_line), 32'h0);
    bus.wb_full = 1'b0;
    wait_done("held_second");
    drain_check();

    // reset asserted while WR1 waits for ack
    stage_full(); hang_cfg = 1'b1; commit();
    e.addr = 32'h0000_2000; e.data = 32'hA500_0000; e.be = 4'hF; q_wr.push_back(e);
    e.addr = 32'h0000_2004; e.data = 32'hA500_0001; q_wr.push_back(e);
    q_rd.push_back(0);
    bus.wb_full = 1'b1;
    @(negedge clk);
    bus.wb_full = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.wb_word) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr1", 32'(n < 50), 32'h1);
    #3 rst = 1'b0;
    #1 chk_zero("async_rst");
    q_wr.delete(); q_rd.delete(); q_clr.delete(); q_lat.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hang_cfg = 1'b0; commit();
    repeat (3) @(negedge clk);
    chk("post_rst_busy",    32'(bus.busy),    32'h0);
    chk("post_rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("post_rst_wb_rd",   32'(bus.wb_rd),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
